encryption: RTL and testbench

ENCRYPTION -- requirements
Module: encryption

---
 rtl/encryption.sv | 85 ++++++++
 tb/tb_encryption.sv | 131 +++++++++++++
 2 files changed

// File: rtl/encryption.sv
// RSA modular exponentiator: continuously recomputes output_e = data_rx^E_EXP mod N_MOD
// using right-to-left square-and-multiply, one exponent bit per clock.
module encryption #(
    parameter logic [31:0] N_MOD = 32'd3233,
    parameter logic [31:0] E_EXP = 32'd17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_rx,
    output logic [31:0] output_e
);

    typedef enum logic {
        LOAD    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] base_r, base_s;
    logic [31:0] acc_r, acc_s;
    logic [31:0] exp_r, exp_s;
    logic [31:0] out_r, out_s;

    // Full 64-bit product reduced mod N_MOD; nothing is truncated before the reduction.
    function automatic logic [31:0] mod_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        prod = {32'd0, a} * {32'd0, b};
        return 32'(prod % {32'd0, N_MOD});
    endfunction

    // Next-state and datapath update for the LOAD/COMPUTE sequence.
    always_comb begin
        state_s = state_r;
        base_s  = base_r;
        acc_s   = acc_r;
        exp_s   = exp_r;
        out_s   = out_r;
        case (state_r)
            LOAD: begin
                // data_rx is captured only here, so later changes cannot disturb this run
                base_s  = data_rx % N_MOD;
                acc_s   = 32'd1 % N_MOD;
                exp_s   = E_EXP;
                state_s = COMPUTE;
            end
            COMPUTE: begin
                if (exp_r != 32'd0) begin
                    if (exp_r[0]) begin
                        acc_s = mod_mul(acc_r, base_r);
                    end else begin
                        acc_s = acc_r;
                    end
                    base_s = mod_mul(base_r, base_r);
                    exp_s  = {1'b0, exp_r[31:1]};
                end else begin
                    out_s   = acc_r;
                    state_s = LOAD;
                end
            end
            default: begin
                state_s = LOAD;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run in progress and clears the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= LOAD;
            base_r  <= 32'd0;
            acc_r   <= 32'd0;
            exp_r   <= 32'd0;
            out_r   <= 32'd0;
        end else begin
            state_r <= state_s;
            base_r  <= base_s;
            acc_r   <= acc_s;
            exp_r   <= exp_s;
            out_r   <= out_s;
        end
    end

    assign output_e = out_r;

endmodule

// File: tb/tb_encryption.sv
// Directed self-checking bench for encryption: default key, decryption key and
// zero-exponent instances, input reduction, data_rx isolation and mid-run reset.
module tb_encryption;

    logic        clk;
    logic        rst;
    logic [31:0] data_rx;
    logic [31:0] dec_data;
    logic [31:0] enc_out;
    logic [31:0] dec_out;
    logic [31:0] zero_out;

    int n_cmp;
    int n_err;

    encryption u_enc (
        .clk      (clk),
        .rst      (rst),
        .data_rx  (data_rx),
        .output_e (enc_out)
    );

    encryption #(.N_MOD(32'd3233), .E_EXP(32'd2753)) u_dec (
        .clk      (clk),
        .rst      (rst),
        .data_rx  (dec_data),
        .output_e (dec_out)
    );

    encryption #(.N_MOD(32'd3233), .E_EXP(32'd0)) u_zero (
        .clk      (clk),
        .rst      (rst),
        .data_rx  (data_rx),
        .output_e (zero_out)
    );

    // Free-running 10 ns clock, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starting right after a result edge: run one full 7-edge computation.
    task automatic run_one(input string tag, input logic [31:0] din,
                           input logic [31:0] prev, input logic [31:0] expv);
        data_rx = din;
        repeat (6) step();
        check_val({tag, "_hold"}, enc_out, prev);
        step();
        check_val(tag, enc_out, expv);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b0;
        data_rx  = 32'd2;
        dec_data = 32'd2790;
        #2;
        check_val("reset_enc", enc_out, 32'd0);
        check_val("reset_dec", dec_out, 32'd0);
        #8;
        rst = 1'b1;

        // 14 edges after release: encrypt result at 7 (and again at 14), decrypt at 14, e=0 at 2.
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k < 7) check_val($sformatf("enc_edge%0d", k), enc_out, 32'd0);
            else       check_val($sformatf("enc_edge%0d", k), enc_out, 32'd1752);
            if (k < 14) check_val($sformatf("dec_edge%0d", k), dec_out, 32'd0);
            else        check_val("dec_roundtrip", dec_out, 32'd65);
            if (k == 1) check_val("e0_edge1", zero_out, 32'd0);
            if (k == 2) check_val("e0_result", zero_out, 32'd1);
        end

        run_one("m65", 32'd65, 32'd1752, 32'd2790);
        run_one("m0", 32'd0, 32'd2790, 32'd0);
        run_one("m1", 32'd1, 32'd0, 32'd1);
        run_one("m_n_plus_2", 32'd3235, 32'd1, 32'd1752);
        run_one("m0_again", 32'd0, 32'd1752, 32'd0);

        // data_rx changes mid-computation: current run keeps the captured 2.
        data_rx = 32'd2;
        repeat (3) step();
        data_rx = 32'd65;
        repeat (3) step();
        check_val("iso_hold", enc_out, 32'd0);
        step();
        check_val("iso_first", enc_out, 32'd1752);
        repeat (7) step();
        check_val("iso_next", enc_out, 32'd2790);

        // Reset asserted just after the 4th edge of a run that would produce 1752.
        data_rx = 32'd2;
        repeat (4) step();
        rst = 1'b0;
        #1;
        check_val("abort_clear", enc_out, 32'd0);
        #3;
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k < 7) check_val($sformatf("post_rst_edge%0d", k), enc_out, 32'd0);
            else       check_val("post_rst_result", enc_out, 32'd1752);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
